adder_inverse: RTL and testbench



---
 rtl/adder_inverse.sv | 106 ++++++++++
 tb/tb_adder_inverse.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_inverse.sv
// Bit-serial operand recovery for the 4-bit adder: b = s - a.
// Flags sums that no pair of W-bit operands could have produced.
module adder_inverse #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W:0]   s_i,
  input  logic [W-1:0] a_i,
  output logic         done_o,
  output logic [W-1:0] b_o,
  output logic         err_o
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [W:0]    r_s;
  logic [W:0]    r_a;
  logic [W:0]    r_d;
  logic          r_borrow;
  logic [CW-1:0] r_cnt;

  logic          w_sb;
  logic          w_ab;
  logic          w_d;
  logic          w_bo;
  logic [W:0]    w_dnext;
  logic          w_last;

  // Full-subtractor cell for the current LSB of the shift registers
  always_comb begin
    w_sb    = r_s[0];
    w_ab    = r_a[0];
    w_d     = w_sb ^ w_ab ^ r_borrow;
    w_bo    = (~w_sb & w_ab) | (~w_sb & r_borrow)
            | (w_ab & r_borrow);
    w_dnext = {w_d, r_d[W:1]};
    w_last  = (r_cnt == CW'(W));
  end

  // Control FSM, serial datapath and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_s      <= '0;
      r_a      <= '0;
      r_d      <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      ready_o  <= 1'b1;
      done_o   <= 1'b0;
      b_o      <= '0;
      err_o    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          done_o <= 1'b0;
          if (valid_i) begin
            r_s      <= s_i;
            r_a      <= {1'b0, a_i};
            r_d      <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            ready_o  <= 1'b0;
            r_state  <= CALC;
          end else begin
            ready_o <= 1'b1;
          end
        end
        CALC: begin
          r_s      <= {1'b0, r_s[W:1]};
          r_a      <= {1'b0, r_a[W:1]};
          r_d      <= w_dnext;
          r_borrow <= w_bo;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            b_o     <= w_dnext[W-1:0];
            err_o   <= w_bo | w_dnext[W];
            done_o  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          done_o  <= 1'b0;
          ready_o <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          done_o  <= 1'b0;
          ready_o <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_inverse.sv
// Self-checking bench for adder_inverse: directed cases, handshake
// timing, async reset, random and exhaustive arithmetic checks.
module tb_adder_inverse;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       valid_i;
  logic       ready_o;
  logic [4:0] s_i;
  logic [3:0] a_i;
  logic       done_o;
  logic [3:0] b_o;
  logic       err_o;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  adder_inverse #(.W(4)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .s_i     (s_i),
    .a_i     (a_i),
    .done_o  (done_o),
    .b_o     (b_o),
    .err_o   (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Cycle counter for measuring acceptance spacing
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_b(input int s, input int a);
    return (s - a + 32) % 16;
  endfunction

  function automatic int ref_err(input int s, input int a);
    return ((s < a) || (s - a > 15)) ? 1 : 0;
  endfunction

  // Called at a negedge; advances until ready_o is seen high
  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!ready_o && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    if (!ready_o) chk({tag, "_ready_timeout"}, 0, 1);
  endtask

  // One full transaction: accept, scramble inputs, await done, check
  task automatic run(input int s, input int a, input string tag,
                     input bit chk_lat);
    int  k;
    bit  got;
    wait_ready(tag);
    valid_i = 1'b1;
    s_i     = 5'(s);
    a_i     = 4'(a);
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    s_i     = 5'($urandom);
    a_i     = 4'($urandom);
    k   = 1;
    got = 1'b0;
    while (k <= 20 && !got) begin
      if (done_o) got = 1'b1;
      else begin
        @(negedge clk_i);
        k++;
      end
    end
    chk({tag, "_done_seen"}, int'(got), 1);
    if (got) begin
      if (chk_lat) chk({tag, "_latency"}, k, 6);
      chk({tag, "_b"}, int'(b_o), ref_b(s, a));
      chk({tag, "_err"}, int'(err_o), ref_err(s, a));
      chk({tag, "_ready_vs_done"}, int'(ready_o), 0);
    end
  endtask

  initial begin
    int acc[$];
    int k;
    int seen;
    int a;
    int b;
    bit any_done;

    rst_i   = 1'b1;
    valid_i = 1'b0;
    s_i     = '0;
    a_i     = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_ready", int'(ready_o), 1);
    chk("rst_done", int'(done_o), 0);
    chk("rst_b", int'(b_o), 0);
    chk("rst_err", int'(err_o), 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    run(12, 5, "d12_5", 1'b1);
    run(30, 15, "d30_15", 1'b1);
    run(0, 0, "d0_0", 1'b1);
    run(31, 15, "d31_15", 1'b1);
    run(3, 9, "d3_9", 1'b1);

    // Requests during CALC must be ignored
    wait_ready("ign");
    valid_i = 1'b1;
    s_i     = 5'd12;
    a_i     = 4'd5;
    @(posedge clk_i);
    @(negedge clk_i);
    s_i = 5'd20;
    a_i = 4'd1;
    for (int i = 0; i < 5; i++) begin
      valid_i = ~valid_i;
      chk("ign_ready_low", int'(ready_o), 0);
      @(negedge clk_i);
    end
    valid_i = 1'b0;
    chk("ign_done", int'(done_o), 1);
    chk("ign_b", int'(b_o), 7);
    chk("ign_err", int'(err_o), 0);
    @(negedge clk_i);
    chk("ign_no_extra_txn", int'(ready_o), 1);

    // Continuous valid: acceptances every 7 cycles
    s_i     = 5'd12;
    a_i     = 4'd5;
    valid_i = 1'b1;
    k = 0;
    while (acc.size() < 3 && k < 40) begin
      if (ready_o) acc.push_back(cyc);
      @(negedge clk_i);
      k++;
    end
    valid_i = 1'b0;
    chk("b2b_count", acc.size(), 3);
    if (acc.size() == 3) begin
      chk("b2b_gap1", acc[1] - acc[0], 7);
      chk("b2b_gap2", acc[2] - acc[1], 7);
    end
    seen = 0;
    while (!ready_o && seen < 20) begin
      @(negedge clk_i);
      seen++;
    end
    chk("b2b_b", int'(b_o), 7);

    // Async reset during the third CALC cycle
    valid_i = 1'b1;
    s_i     = 5'd13;
    a_i     = 4'd2;
    @(posedge clk_i);
    valid_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_b", int'(b_o), 0);
    chk("arst_err", int'(err_o), 0);
    chk("arst_ready", int'(ready_o), 1);
    chk("arst_done", int'(done_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    any_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (done_o) any_done = 1'b1;
    end
    chk("arst_no_done", int'(any_done), 0);
    run(9, 4, "arst_next", 1'b1);

    // Random valid pairs: s = a + b always recovers b
    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      run(a + b, a, "rnd", 1'b0);
      chk("rnd_b_direct", int'(b_o), b);
    end

    // Every (s, a) combination
    for (int s = 0; s < 32; s++) begin
      for (int x = 0; x < 16; x++) begin
        run(s, x, "exh", 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
